// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the up/down counter family
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable saturating down-counter with pause, done pulse and auto-reload
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] val_out,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != ZERO) state_d = pause ? HOLD : RUN;
                        else                 done_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        // Expiry: auto_reload only matters here, on this edge
                        done_d = 1'b1;
                        if (auto_reload && (reload_q != ZERO)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (!pause) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign val_out = count_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       auto_reload;
    logic [3:0] val_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .val_out     (val_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int v, input int b, input int d);
        check_eq({tag, ".val"},  int'(val_out), v);
        check_eq({tag, ".busy"}, int'(busy), b);
        check_eq({tag, ".done"}, int'(done), d);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = 4'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
        pause = 1'b0; auto_reload = 1'b0;
        #3;
        expect_out("reset", 0, 0, 0);
        #4 reset = 1'b0;

        // 1: basic countdown from 5
        do_load(5);
        expect_out("t1.load", 5, 0, 0);
        do_start();
        expect_out("t1.start", 5, 1, 0);
        for (int e = 4; e >= 1; e--) begin
            tick();
            expect_out("t1.run", e, 1, 0);
        end
        tick();
        expect_out("t1.expire", 0, 0, 1);
        tick();
        expect_out("t1.after", 0, 0, 0);

        // 2: auto-reload period 3, then load 0
        auto_reload = 1'b1;
        do_load(3);
        do_start();
        expect_out("t2.start", 3, 1, 0);
        for (int k = 0; k < 2; k++) begin
            tick(); expect_out("t2.c2", 2, 1, 0);
            tick(); expect_out("t2.c1", 1, 1, 0);
            tick(); expect_out("t2.reload", 3, 1, 1);
        end
        do_load(0);
        expect_out("t2.load0", 0, 0, 0);
        auto_reload = 1'b0;
        tick();
        expect_out("t2.idle", 0, 0, 0);

        // 3: pause at 7 for 4 cycles
        do_load(9);
        do_start();
        tick(); tick();
        expect_out("t3.at7", 7, 1, 0);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out("t3.hold", 7, 1, 0);
        end
        pause = 1'b0;
        tick();
        expect_out("t3.resume", 7, 1, 0);
        for (int e = 6; e >= 1; e--) begin
            tick();
            expect_out("t3.run", e, 1, 0);
        end
        tick();
        expect_out("t3.expire", 0, 0, 1);

        // 4: asynchronous reset mid-run
        do_load(9);
        do_start();
        tick(); tick(); tick();
        expect_out("t4.at6", 6, 1, 0);
        #2 reset = 1'b1;
        #1;
        expect_out("t4.async", 0, 0, 0);
        reset = 1'b0;
        do_start();
        expect_out("t4.start0", 0, 0, 1);
        tick();
        expect_out("t4.after", 0, 0, 0);

        // 5: load overrides start mid-run, then count 15 down
        do_load(9);
        do_start();
        tick();
        expect_out("t5.run", 8, 1, 0);
        load = 1'b1; load_val = 4'd15; start = 1'b1;
        tick();
        load = 1'b0;
        expect_out("t5.load", 15, 0, 0);
        tick();
        start = 1'b0;
        expect_out("t5.start", 15, 1, 0);
        for (int e = 14; e >= 1; e--) begin
            tick();
            check_eq("t5.run.val", int'(val_out), e);
        end
        tick();
        expect_out("t5.expire", 0, 0, 1);

        // 6: start with pause enters HOLD; start in HOLD ignored
        do_load(4);
        start = 1'b1; pause = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t6.hold", 4, 1, 0);
        tick();
        expect_out("t6.hold2", 4, 1, 0);
        do_start();
        expect_out("t6.restart", 4, 1, 0);
        pause = 1'b0;
        tick();
        expect_out("t6.resume", 4, 1, 0);
        tick();
        expect_out("t6.run", 3, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
